// File: rtl/wb_trace_queue_if.sv
// Bundles the CPU observation ports, the trace output stream and the loss indicators.
// The master drives the CPU side and accepts the stream; the slave is the queue.
interface wb_trace_queue_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      m_inst_addr;
  logic [31:0]      m_data_addr;
  logic [31:0]      m_data_wdata;
  logic [3:0]       m_data_byteen;
  logic [31:0]      m_data_rdata;
  logic [31:0]      w_inst_addr;
  logic             w_grf_we;
  logic [4:0]       w_grf_addr;
  logic [31:0]      w_grf_wdata;
  logic             out_valid;
  logic             out_ready;
  logic             out_type;
  logic [31:0]      out_pc;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output m_inst_addr, m_data_addr, m_data_wdata, m_data_byteen, m_data_rdata,
    output w_inst_addr, w_grf_we, w_grf_addr, w_grf_wdata, out_ready,
    input  out_valid, out_type, out_pc, out_addr, out_data, overflow, drop_cnt
  );

  modport slave (
    input  m_inst_addr, m_data_addr, m_data_wdata, m_data_byteen, m_data_rdata,
    input  w_inst_addr, w_grf_we, w_grf_addr, w_grf_wdata, out_ready,
    output out_valid, out_type, out_pc, out_addr, out_data, overflow, drop_cnt
  );
endinterface

// File: rtl/wb_trace_queue.sv
// Ordered trace FIFO for M-stage stores and W-stage GRF writes, up to two events per cycle.
// Events that find no room are counted and flagged rather than silently lost.
module wb_trace_queue #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  wb_trace_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic        typ;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t           fifo [DEPTH];
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             overflow_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic             mem_evt;
  logic             grf_evt;
  logic             deq;
  logic             keep_mem;
  logic             keep_grf;
  logic [1:0]       enq_n;
  logic [1:0]       n_drop;
  logic [PTR_W+1:0] space;
  logic [31:0]      merged;
  logic [CNT_W:0]   drop_sum;
  entry_t           mem_ent;
  entry_t           grf_ent;
  entry_t           head;

  assign mem_evt = (bus.m_data_byteen != 4'b0000);
  assign grf_evt = bus.w_grf_we && (bus.w_grf_addr != 5'd0);
  assign deq     = (count != '0) && bus.out_ready;
  assign space   = (PTR_W+2)'(DEPTH) - {1'b0, count} + {{(PTR_W+1){1'b0}}, deq};

  always_comb begin
    merged = bus.m_data_rdata;
    for (int i = 0; i < 4; i++) begin
      if (bus.m_data_byteen[i]) merged[8*i +: 8] = bus.m_data_wdata[8*i +: 8];
    end
  end

  // The store always claims the first free slot, so it survives when only one slot is left.
  assign keep_mem = mem_evt && (space != '0);
  assign keep_grf = grf_evt && (space > {{(PTR_W+1){1'b0}}, mem_evt});
  assign enq_n    = {1'b0, keep_mem} + {1'b0, keep_grf};
  assign n_drop   = {1'b0, mem_evt && !keep_mem} + {1'b0, grf_evt && !keep_grf};
  assign drop_sum = {1'b0, drop_cnt_q} + {{(CNT_W-1){1'b0}}, n_drop};

  assign mem_ent = '{typ: 1'b1, pc: bus.m_inst_addr,
                     addr: {bus.m_data_addr[31:2], 2'b00}, data: merged};
  assign grf_ent = '{typ: 1'b0, pc: bus.w_inst_addr,
                     addr: {27'd0, bus.w_grf_addr}, data: bus.w_grf_wdata};

  always_ff @(posedge clk) begin
    if (keep_mem) fifo[wr_ptr] <= mem_ent;
    if (keep_grf) fifo[keep_mem ? wr_ptr + 1'b1 : wr_ptr] <= grf_ent;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      count  <= count + {{(PTR_W-1){1'b0}}, enq_n} - {{PTR_W{1'b0}}, deq};
      rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, deq};
      wr_ptr <= wr_ptr + {{(PTR_W-2){1'b0}}, enq_n};
      if (n_drop != 2'd0) begin
        overflow_q <= 1'b1;
        drop_cnt_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
    end
  end

  // Head fields read as zero whenever the queue is empty, including straight out of reset.
  assign head          = fifo[rd_ptr];
  assign bus.out_valid = (count != '0);
  assign bus.out_type  = bus.out_valid ? head.typ  : 1'b0;
  assign bus.out_pc    = bus.out_valid ? head.pc   : 32'd0;
  assign bus.out_addr  = bus.out_valid ? head.addr : 32'd0;
  assign bus.out_data  = bus.out_valid ? head.data : 32'd0;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: doc/wb_trace_queue.md
Name: wb_trace_queue

Overview:
- Sits directly downstream of the CPU's observation ports and upstream of the trace checker/logger.
- Per cycle, captures up to two retire events from the CPU:
  - a data-memory store seen on the M-stage bus, with the byte-lane merge done internally;
  - a GRF write seen on the W-stage port.
- Buffers both in one ordered FIFO and presents them one per cycle on a valid/ready stream.
- Flags overflow when the consumer stalls too long, so trace loss is never silent.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 4.
CNT_W, 16, width of the saturating drop counter.

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
m_inst_addr  in  32  PC of the instruction in M stage
m_data_addr  in  32  byte address of store
m_data_wdata  in  32  store data, lane-aligned
m_data_byteen  in  4  store byte enables; 0 = no store
m_data_rdata  in  32  current memory word at m_data_addr (for merge)
w_inst_addr  in  32  PC of the instruction in W stage
w_grf_we  in  1  GRF write enable
w_grf_addr  in  5  GRF destination register
w_grf_wdata  in  32  GRF write data
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head this cycle
out_type  out  1  0 = GRF write, 1 = memory store
out_pc  out  32  instruction address of event
out_addr  out  32  memory: word-aligned address (addr & 0xFFFFFFFC); GRF: {27'b0, reg}
out_data  out  32  memory: merged word; GRF: write data
overflow  out  1  sticky; set on any dropped event
drop_cnt  out  CNT_W  dropped-event count, saturates at all-ones

Behaviour:
- Reset (async):
  - count = 0; read and write pointers = 0.
  - out_valid = 0; out_type/out_pc/out_addr/out_data = 0.
  - overflow = 0; drop_cnt = 0.
- Event qualification, sampled at posedge:
  - mem_evt = (m_data_byteen != 0).
  - grf_evt = w_grf_we && (w_grf_addr != 0). Writes to $0 are never enqueued.
- Merge rule: start from m_data_rdata; for each byteen[i] set, replace byte lane i with m_data_wdata lane i. Lane 3 = [31:24], lane 0 = [7:0].
- Ordering: when both events occur in the same cycle, the mem event is enqueued first, then the grf event. The output stream preserves arrival order.
- Dequeue: fires when out_valid && out_ready at posedge; the head advances.
- out_valid = (count != 0). Outputs are driven combinationally from the head entry and are stable while out_valid && !out_ready.
- Latency: an event sampled at posedge N appears on outputs after that edge, so the earliest consume is edge N+1.
- Space: space = DEPTH - count + (dequeue fires). An enqueue may reuse the slot freed in the same cycle.
- Full handling:
  - If space == 0: all new events are dropped.
  - If space == 1 and two events arrive: the mem event is kept and the grf event dropped.
  - Every dropped event increments drop_cnt by 1 (by 2 if both dropped), saturating, and sets overflow.
- count update: count_next = count + enq_n - deq, where enq_n is 0..2; the bound 0..DEPTH is always held.
- Pointers wrap modulo DEPTH.
- Reset asserted mid-stream discards all queued entries; no partial entry is ever emitted.
- overflow and drop_cnt clear only on reset.

Test Plan:
- GRF only: w_grf_we=1, addr=8, wdata=0x1234, pc=0x3004, out_ready=1 -> next cycle out_valid=1, type=0, pc=0x3004, addr=0x8, data=0x00001234; one-cycle pulse.
- $0 filter: w_grf_we=1, addr=0, wdata=0xFFFFFFFF -> out_valid stays 0, drop_cnt=0.
- Byte merge: rdata=0xAABBCCDD, wdata=0x11223344, byteen=4'b0110, addr=0x0000001E, pc=0x3010 -> type=1, addr=0x0000001C, data=0xAA2233DD.
- Simultaneous events: mem store (byteen=4'hF, addr=0x40, wdata=0x5) and GRF write (reg 3, 0x7) in one cycle, out_ready=1 -> mem record on first cycle, GRF record on the next.
- Overflow: out_ready=0, one grf event per cycle for DEPTH+3 cycles -> count=16, overflow=1, drop_cnt=3. Then out_ready=1 -> exactly 16 records drain, in order.
- Async reset mid-drain: with 5 entries queued, pulse reset between edges -> out_valid=0 and drop_cnt=0 immediately, with no clock edge needed.
